sel_arb_mux: RTL
================

# sel_arb_mux

Parametrised, registered N-channel selector for the SISC datapath. It generalises the fixed 3-input, 4-bit select to NCH channels of WIDTH bits, each with a valid/ready handshake. Channels are chosen by round-robin or fixed-priority arbitration, or by an explicit select override. The chosen word passes through one output register stage, so producers such as register-address sources, writeback candidates and bus requesters can share a single downstream consumer without combinational paths from input data to output data.

## Interface
- WIDTH, 16, data width per channel
- NCH, 4, number of input channels (2..16)
- CW, 2, channel-index width; 2^CW >= NCH required
- RR, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)

- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_data  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  NCH  channel i offers a word
- in_ready  out  NCH  channel i word accepted this cycle (one-hot or zero)
- force_en  in  1  override arbitration with force_sel
- force_sel  in  CW  channel to take when force_en=1
- out_data  out  WIDTH  registered selected word
- out_ch  out  CW  index of channel that supplied out_data
- out_valid  out  1  out_data/out_ch hold a word
- out_ready  in  1  consumer accepts word when out_valid=1

## Operation
- The output register is "loadable" when out_valid=0 or (out_valid=1 and out_ready=1).
- Grant selection is combinational from in_valid, force_en, force_sel and last_grant:
  - force_en=1: grant is force_sel if force_sel < NCH and in_valid[force_sel]=1; otherwise no grant. Other channels are never granted while force_en=1.
  - RR=1: grant is the first i with in_valid[i]=1, searching last_grant+1, last_grant+2, ..., wrapping at NCH-1 -> 0, ending at last_grant.
  - RR=0: grant is the lowest i with in_valid[i]=1.
- in_ready[grant] = loadable and a grant exists; all other in_ready bits are 0. in_ready depends combinationally on out_ready; there is no path from in_data to any output in the same cycle.
- Transfer on channel g (in_valid[g] & in_ready[g]) at edge:
  - out_data <= in_data[g]
  - out_ch <= g
  - out_valid <= 1
  - last_grant <= g (updated in RR mode and in forced mode)
- Drain without load (out_valid & out_ready, no grant): out_valid <= 0; out_data and out_ch hold their values.
- Stall (out_valid=1, out_ready=0): out_data, out_ch and out_valid hold; in_ready = 0.
- last_grant does not change on cycles without a transfer.

## Timing
- Reset (async assert, sync-safe release):
  - out_valid=0, out_data=0, out_ch=0
  - last_grant=NCH-1, so channel 0 has first priority
  - in_ready=0 while rst=1
- Latency: 1 cycle. A transfer at edge k gives out_valid=1 and the new data visible after edge k.
- Throughput: 1 word per cycle when out_ready is held 1. Simultaneous drain and load in the same cycle produces no bubble.
- Fairness (RR=1): with all NCH channels continuously valid and out_ready=1, each channel is granted exactly once per NCH consecutive transfers, in index order.
- A channel that deasserts in_valid before being granted loses nothing; arbitration simply skips it.
- Changing force_en mid-stream takes effect for the next grant decision. Round-robin resumes from the last channel granted, including a forced grant.
- rst asserted mid-transfer: the held word is discarded, out_valid drops immediately, and no in_ready pulse is produced.

## Test plan
- Reset check: assert rst with all in_valid=1 -> out_valid=0, in_ready=0000, out_data=0. After release, the first grant goes to ch0 and out_ch=0 one cycle later.
- RR fairness: NCH=4, all valid, out_ready=1, data ch i = 16'hA000+i, for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 with matching out_data and no bubbles.
- Fixed priority: RR=0, ch1 and ch3 valid for 3 cycles -> ch1 granted every cycle and in_ready[3]=0 throughout.
- Backpressure: word from ch2 (16'h1234) loaded, then out_ready=0 for 3 cycles -> out_data=16'h1234 and out_valid=1 hold, in_ready=0. Raise out_ready -> the next word is loaded the same cycle.
- Force override: force_en=1, force_sel=2, ch0 and ch2 valid -> only ch2 granted. Set force_sel=3 with ch3 invalid -> no grant, and out_valid clears after drain.
- Mid-operation reset: rst asserted asynchronously while out_valid=1 and out_ready=0 -> out_valid=0 before the next edge, and last_grant restarts so ch0 is granted first.

Source files
------------

// File: rtl/sel_arb_mux_if.sv
// Handshake bundle for sel_arb_mux: NCH producer channels in, one registered consumer port out.
// slave = the arbiter itself, master = whoever drives producers/consumer.
interface sel_arb_mux_if #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int CW    = 2
);
  logic [NCH-1:0][WIDTH-1:0] in_data;
  logic [NCH-1:0]            in_valid;
  logic [NCH-1:0]            in_ready;
  logic                      force_en;
  logic [CW-1:0]             force_sel;
  logic [WIDTH-1:0]          out_data;
  logic [CW-1:0]             out_ch;
  logic                      out_valid;
  logic                      out_ready;

  modport slave (
    input  in_data, in_valid, force_en, force_sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

  modport master (
    output in_data, in_valid, force_en, force_sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/sel_arb_mux.sv
// Registered N-channel selector: round-robin / fixed-priority / forced grant feeding one
// output register, so no combinational path exists from in_data to any output.

module sel_arb_mux_lane #(
  parameter int WIDTH = 16
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  assign dout = din & {WIDTH{sel}};
endmodule

module sel_arb_mux #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int CW    = 2,
  parameter bit RR    = 1'b1
) (
  input logic          clk,
  input logic          rst,
  sel_arb_mux_if.slave bus
);
  localparam int NP = 1 << CW;

  logic [WIDTH-1:0]          out_data_q, out_data_d;
  logic [CW-1:0]             out_ch_q, out_ch_d;
  logic                      out_valid_q, out_valid_d;
  logic [CW-1:0]             last_grant_q, last_grant_d;

  logic [NP-1:0]             vld_pad;
  logic [NP-1:0]             gnt_oh_pad;
  logic [NCH-1:0]            gnt_oh;
  logic                      gnt_vld;
  logic [CW-1:0]             gnt_idx;
  logic                      loadable;
  logic                      xfer;
  logic [NCH-1:0][WIDTH-1:0] lane_data;
  logic [WIDTH-1:0]          mux_data;

  // Padding to 2^CW lets force_sel index safely; pad bits are never valid.
  assign vld_pad = NP'(bus.in_valid);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (bus.force_en) begin
      if (int'(bus.force_sel) < NCH && vld_pad[bus.force_sel]) begin
        gnt_vld = 1'b1;
        gnt_idx = bus.force_sel;
      end
    end else if (RR) begin
      for (int k = 1; k <= NCH; k++) begin
        if (!gnt_vld && vld_pad[CW'((int'(last_grant_q) + k) % NCH)]) begin
          gnt_vld = 1'b1;
          gnt_idx = CW'((int'(last_grant_q) + k) % NCH);
        end
      end
    end else begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (vld_pad[CW'(i)]) begin
          gnt_vld = 1'b1;
          gnt_idx = CW'(i);
        end
      end
    end
  end

  always_comb begin
    gnt_oh_pad = '0;
    if (gnt_vld) gnt_oh_pad[gnt_idx] = 1'b1;
  end
  assign gnt_oh = gnt_oh_pad[NCH-1:0];

  // rst gates the handshake so no producer sees an accept during reset.
  assign loadable = !out_valid_q || bus.out_ready;
  assign xfer     = loadable && gnt_vld && !rst;

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    sel_arb_mux_lane #(.WIDTH(WIDTH)) u_lane (
      .sel  (gnt_oh[g]),
      .din  (bus.in_data[g]),
      .dout (lane_data[g])
    );
  end

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < NCH; i++) mux_data = mux_data | lane_data[i];
  end

  always_comb begin
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    out_valid_d  = out_valid_q;
    last_grant_d = last_grant_q;
    if (xfer) begin
      out_data_d   = mux_data;
      out_ch_d     = gnt_idx;
      out_valid_d  = 1'b1;
      last_grant_d = gnt_idx;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q   <= '0;
      out_ch_q     <= '0;
      out_valid_q  <= 1'b0;
      last_grant_q <= CW'(NCH - 1);
    end else begin
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      out_valid_q  <= out_valid_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.in_ready  = gnt_oh & {NCH{xfer}};
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;
endmodule
